// File: rtl/fp_taylor_pkg.sv
`default_nettype none
// ============================================================================
// Module : fp_taylor_pkg
// Brief  : Shared constants and state encodings for the Taylor-series
//          floating-point evaluators (asin_taylor_3 and relatives).
// Rev    : 1.0  initial release
// ============================================================================
package fp_taylor_pkg;

    // Series coefficients, IEEE-754 single precision
    localparam logic [31:0] c_asin_c1 = 32'h3E2AAAAB;  // 1/6
    localparam logic [31:0] c_asin_c2 = 32'h3D99999A;  // 3/40

    // Sequencer operation states
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_X2   = 4'd1,
        ST_X3   = 4'd2,
        ST_T1   = 4'd3,
        ST_X5   = 4'd4,
        ST_T2   = 4'd5,
        ST_S1   = 4'd6,
        ST_S2   = 4'd7,
        ST_DONE = 4'd8
    } state_t;

    // Per-operation handshake phase
    typedef enum logic [0:0] {
        PH_ISSUE = 1'b0,
        PH_WAIT  = 1'b1
    } phase_t;

endpackage
`default_nettype wire

// File: rtl/asin_taylor_3_seq.sv
`default_nettype none
// ============================================================================
// Module : asin_taylor_3_seq
// Brief  : Sequencer for asin(x) ~ x + C1*x^3 + C2*x^5. Steps one shared
//          multiplier and one shared adder through seven operations, each
//          split into an operand ISSUE phase and a result WAIT phase.
// Rev    : 1.0  initial release
// ============================================================================
module asin_taylor_3_seq
    import fp_taylor_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_a_stb,
    output logic        mul_b_stb,
    input  logic        mul_a_ack,
    input  logic        mul_b_ack,
    input  logic [31:0] mul_z,
    input  logic        mul_z_stb,
    output logic        mul_z_ack,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_a_stb,
    output logic        add_b_stb,
    input  logic        add_a_ack,
    input  logic        add_b_ack,
    input  logic [31:0] add_z,
    input  logic        add_z_stb,
    output logic        add_z_ack
);

    state_t      r_state;
    phase_t      r_phase;
    logic        r_a_seen;
    logic        r_b_seen;
    logic        r_in_ack;
    logic        r_out_stb;
    logic [31:0] r_out;
    logic [31:0] r_x;
    logic [31:0] r_x2;
    logic [31:0] r_x3;
    logic [31:0] r_x5;
    logic [31:0] r_t1;
    logic [31:0] r_t2;
    logic [31:0] r_s1;

    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic        w_use_add;
    logic        w_op_active;
    logic        w_issue;
    logic        w_wait;
    logic        w_a_hs;
    logic        w_b_hs;
    logic        w_res_stb;
    logic [31:0] w_res;

    // Operand routing and unit selection for the current operation state
    always_comb begin
        w_op_a      = r_x;
        w_op_b      = r_x;
        w_use_add   = 1'b0;
        w_op_active = 1'b1;
        case (r_state)
            ST_X2: begin w_op_a = r_x;  w_op_b = r_x;       end
            ST_X3: begin w_op_a = r_x2; w_op_b = r_x;       end
            ST_T1: begin w_op_a = r_x3; w_op_b = c_asin_c1; end
            ST_X5: begin w_op_a = r_x3; w_op_b = r_x2;      end
            ST_T2: begin w_op_a = r_x5; w_op_b = c_asin_c2; end
            ST_S1: begin w_op_a = r_x;  w_op_b = r_t1; w_use_add = 1'b1; end
            ST_S2: begin w_op_a = r_s1; w_op_b = r_t2; w_use_add = 1'b1; end
            default: w_op_active = 1'b0;
        endcase
    end

    // Both units see the same operands; only the strobes are steered
    assign w_issue   = w_op_active && (r_phase == PH_ISSUE);
    assign w_wait    = w_op_active && (r_phase == PH_WAIT);
    assign mul_a     = w_op_a;
    assign mul_b     = w_op_b;
    assign add_a     = w_op_a;
    assign add_b     = w_op_b;
    assign mul_a_stb = w_issue && !w_use_add && !r_a_seen;
    assign mul_b_stb = w_issue && !w_use_add && !r_b_seen;
    assign add_a_stb = w_issue &&  w_use_add && !r_a_seen;
    assign add_b_stb = w_issue &&  w_use_add && !r_b_seen;
    assign mul_z_ack = w_wait && !w_use_add;
    assign add_z_ack = w_wait &&  w_use_add;
    assign w_a_hs    = w_use_add ? (add_a_stb && add_a_ack) : (mul_a_stb && mul_a_ack);
    assign w_b_hs    = w_use_add ? (add_b_stb && add_b_ack) : (mul_b_stb && mul_b_ack);
    assign w_res_stb = w_use_add ? add_z_stb : mul_z_stb;
    assign w_res     = w_use_add ? add_z : mul_z;

    assign input_a_ack  = r_in_ack;
    assign output_z     = r_out;
    assign output_z_stb = r_out_stb;

    // Main sequencer: accept x, run the seven operations, present the sum
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_phase   <= PH_ISSUE;
            r_a_seen  <= 1'b0;
            r_b_seen  <= 1'b0;
            r_in_ack  <= 1'b0;
            r_out_stb <= 1'b0;
            r_out     <= 32'd0;
            r_x       <= 32'd0;
            r_x2      <= 32'd0;
            r_x3      <= 32'd0;
            r_x5      <= 32'd0;
            r_t1      <= 32'd0;
            r_t2      <= 32'd0;
            r_s1      <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ack <= 1'b1;
                    if (input_a_stb && r_in_ack) begin
                        r_x      <= input_a;
                        r_in_ack <= 1'b0;
                        r_state  <= ST_X2;
                    end
                end
                ST_X2, ST_X3, ST_T1, ST_X5, ST_T2, ST_S1, ST_S2: begin
                    if (r_phase == PH_ISSUE) begin
                        if (w_a_hs)
                            r_a_seen <= 1'b1;
                        if (w_b_hs)
                            r_b_seen <= 1'b1;
                        if ((r_a_seen || w_a_hs) && (r_b_seen || w_b_hs)) begin
                            r_a_seen <= 1'b0;
                            r_b_seen <= 1'b0;
                            r_phase  <= PH_WAIT;
                        end
                    end else if (w_res_stb) begin
                        r_phase <= PH_ISSUE;
                        case (r_state)
                            ST_X2:   begin r_x2 <= w_res; r_state <= ST_X3; end
                            ST_X3:   begin r_x3 <= w_res; r_state <= ST_T1; end
                            ST_T1:   begin r_t1 <= w_res; r_state <= ST_X5; end
                            ST_X5:   begin r_x5 <= w_res; r_state <= ST_T2; end
                            ST_T2:   begin r_t2 <= w_res; r_state <= ST_S1; end
                            ST_S1:   begin r_s1 <= w_res; r_state <= ST_S2; end
                            default: begin
                                r_out     <= w_res;
                                r_out_stb <= 1'b1;
                                r_state   <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_DONE: begin
                    if (output_z_ack) begin
                        r_out_stb <= 1'b0;
                        r_in_ack  <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_phase <= PH_ISSUE;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_adder_2x32.sv
`default_nettype none
// ============================================================================
// Module : fp_adder_2x32
// Brief  : Single-precision adder with stb/ack handshakes on both operands
//          and on the result. Round to nearest even; denormal inputs and
//          underflowing results are flushed to signed zero.
// Rev    : 1.0  initial release
// ============================================================================
module fp_adder_2x32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    localparam logic [1:0] c_st_get  = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_put  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_z;
    logic        r_got_a;
    logic        r_got_b;
    logic [31:0] w_sum;
    logic        w_hs_a;
    logic        w_hs_b;

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [31:0]        big;
        logic [31:0]        sml;
        logic [7:0]         d;
        logic [50:0]        mb;
        logic [50:0]        ms;
        logic [50:0]        sum;
        logic [50:0]        n;
        logic               stk;
        logic               st0;
        int                 pos;
        logic signed [10:0] e;
        logic [24:0]        m;
        logic               g;
        logic               st;
        a_nan  = (&a[30:23]) && (|a[22:0]);
        b_nan  = (&b[30:23]) && (|b[22:0]);
        a_inf  = (&a[30:23]) && !(|a[22:0]);
        b_inf  = (&b[30:23]) && !(|b[22:0]);
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        if (a_nan || b_nan)
            return 32'h7FC00000;
        if (a_inf && b_inf)
            return (a[31] != b[31]) ? 32'h7FC00000 : a;
        if (a_inf)
            return a;
        if (b_inf)
            return b;
        if (a_zero && b_zero)
            return {a[31] & b[31], 31'd0};
        if (a_zero)
            return b;
        if (b_zero)
            return a;
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = big[30:23] - sml[30:23];
        // Hidden one sits at bit 49; 26 guard bits keep alignment exact
        // enough that a sticky bit folded into bit 0 rounds correctly.
        mb = {2'b01, big[22:0], 26'd0};
        ms = {2'b01, sml[22:0], 26'd0};
        if (d > 8'd50) begin
            stk = 1'b1;
            ms  = 51'd0;
        end else begin
            stk = |(ms & ((51'd1 << d) - 51'd1));
            ms  = ms >> d;
        end
        ms[0] = ms[0] | stk;
        sum = (big[31] == sml[31]) ? (mb + ms) : (mb - ms);
        if (sum == 51'd0)
            return 32'd0;
        pos = 0;
        for (int i = 0; i < 51; i++)
            if (sum[i])
                pos = i;
        e = $signed({3'b000, big[30:23]}) + 11'(pos) - 11'sd49;
        if (pos == 50) begin
            n   = sum >> 1;
            st0 = sum[0];
        end else begin
            n   = sum << (49 - pos);
            st0 = 1'b0;
        end
        m  = {1'b0, n[49:26]};
        g  = n[25];
        st = (|n[24:0]) | st0;
        if (g && (st || m[0]))
            m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 11'sd1;
        end
        if (e >= 11'sd255)
            return {big[31], 8'hFF, 23'd0};
        if (e <= 11'sd0)
            return {big[31], 31'd0};
        return {big[31], e[7:0], m[22:0]};
    endfunction

    assign w_sum        = fp_add(r_a, r_b);
    assign input_a_ack  = (r_state == c_st_get) && !r_got_a;
    assign input_b_ack  = (r_state == c_st_get) && !r_got_b;
    assign w_hs_a       = input_a_stb && input_a_ack;
    assign w_hs_b       = input_b_stb && input_b_ack;
    assign output_z     = r_z;
    assign output_z_stb = (r_state == c_st_put);

    // Collect both operands, compute for one cycle, then offer the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_get;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_z     <= 32'd0;
            r_got_a <= 1'b0;
            r_got_b <= 1'b0;
        end else begin
            case (r_state)
                c_st_get: begin
                    if (w_hs_a) begin
                        r_a     <= input_a;
                        r_got_a <= 1'b1;
                    end
                    if (w_hs_b) begin
                        r_b     <= input_b;
                        r_got_b <= 1'b1;
                    end
                    if ((r_got_a || w_hs_a) && (r_got_b || w_hs_b)) begin
                        r_got_a <= 1'b0;
                        r_got_b <= 1'b0;
                        r_state <= c_st_calc;
                    end
                end
                c_st_calc: begin
                    r_z     <= w_sum;
                    r_state <= c_st_put;
                end
                c_st_put: begin
                    if (output_z_ack)
                        r_state <= c_st_get;
                end
                default: r_state <= c_st_get;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mult2x32.sv
`default_nettype none
// ============================================================================
// Module : fp_mult2x32
// Brief  : Single-precision multiplier with stb/ack handshakes on both
//          operands and on the result. Round to nearest even; denormal
//          inputs and underflowing results are flushed to signed zero.
// Rev    : 1.0  initial release
// ============================================================================
module fp_mult2x32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    localparam logic [1:0] c_st_get  = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_put  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_z;
    logic        r_got_a;
    logic        r_got_b;
    logic [31:0] w_prod;
    logic        w_hs_a;
    logic        w_hs_b;

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0]        p;
        logic signed [10:0] e;
        logic [24:0]        m;
        logic               g;
        logic               st;
        s      = a[31] ^ b[31];
        a_nan  = (&a[30:23]) && (|a[22:0]);
        b_nan  = (&b[30:23]) && (|b[22:0]);
        a_inf  = (&a[30:23]) && !(|a[22:0]);
        b_inf  = (&b[30:23]) && !(|b[22:0]);
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
        if (p[47]) begin
            m  = {1'b0, p[47:24]};
            g  = p[23];
            st = |p[22:0];
            e  = e + 11'sd1;
        end else begin
            m  = {1'b0, p[46:23]};
            g  = p[22];
            st = |p[21:0];
        end
        if (g && (st || m[0]))
            m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 11'sd1;
        end
        if (a_nan || b_nan)
            return 32'h7FC00000;
        if (a_inf || b_inf)
            return (a_zero || b_zero) ? 32'h7FC00000 : {s, 8'hFF, 23'd0};
        if (a_zero || b_zero)
            return {s, 31'd0};
        if (e >= 11'sd255)
            return {s, 8'hFF, 23'd0};
        if (e <= 11'sd0)
            return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    assign w_prod       = fp_mul(r_a, r_b);
    assign input_a_ack  = (r_state == c_st_get) && !r_got_a;
    assign input_b_ack  = (r_state == c_st_get) && !r_got_b;
    assign w_hs_a       = input_a_stb && input_a_ack;
    assign w_hs_b       = input_b_stb && input_b_ack;
    assign output_z     = r_z;
    assign output_z_stb = (r_state == c_st_put);

    // Collect both operands, compute for one cycle, then offer the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_get;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_z     <= 32'd0;
            r_got_a <= 1'b0;
            r_got_b <= 1'b0;
        end else begin
            case (r_state)
                c_st_get: begin
                    if (w_hs_a) begin
                        r_a     <= input_a;
                        r_got_a <= 1'b1;
                    end
                    if (w_hs_b) begin
                        r_b     <= input_b;
                        r_got_b <= 1'b1;
                    end
                    if ((r_got_a || w_hs_a) && (r_got_b || w_hs_b)) begin
                        r_got_a <= 1'b0;
                        r_got_b <= 1'b0;
                        r_state <= c_st_calc;
                    end
                end
                c_st_calc: begin
                    r_z     <= w_prod;
                    r_state <= c_st_put;
                end
                c_st_put: begin
                    if (output_z_ack)
                        r_state <= c_st_get;
                end
                default: r_state <= c_st_get;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/asin_taylor_3.sv
`default_nettype none
// ============================================================================
// Module : asin_taylor_3
// Brief  : Third-order Taylor approximation of asin(x) in single precision.
//          Holds the shared multiplier/adder and the sequencer driving them.
// Rev    : 1.0  initial release
// ============================================================================
module asin_taylor_3 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    logic [31:0] w_mul_a;
    logic [31:0] w_mul_b;
    logic        w_mul_a_stb;
    logic        w_mul_b_stb;
    logic        w_mul_a_ack;
    logic        w_mul_b_ack;
    logic [31:0] w_mul_z;
    logic        w_mul_z_stb;
    logic        w_mul_z_ack;
    logic [31:0] w_add_a;
    logic [31:0] w_add_b;
    logic        w_add_a_stb;
    logic        w_add_b_stb;
    logic        w_add_a_ack;
    logic        w_add_b_ack;
    logic [31:0] w_add_z;
    logic        w_add_z_stb;
    logic        w_add_z_ack;

    asin_taylor_3_seq u_seq (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack),
        .mul_a        (w_mul_a),
        .mul_b        (w_mul_b),
        .mul_a_stb    (w_mul_a_stb),
        .mul_b_stb    (w_mul_b_stb),
        .mul_a_ack    (w_mul_a_ack),
        .mul_b_ack    (w_mul_b_ack),
        .mul_z        (w_mul_z),
        .mul_z_stb    (w_mul_z_stb),
        .mul_z_ack    (w_mul_z_ack),
        .add_a        (w_add_a),
        .add_b        (w_add_b),
        .add_a_stb    (w_add_a_stb),
        .add_b_stb    (w_add_b_stb),
        .add_a_ack    (w_add_a_ack),
        .add_b_ack    (w_add_b_ack),
        .add_z        (w_add_z),
        .add_z_stb    (w_add_z_stb),
        .add_z_ack    (w_add_z_ack)
    );

    fp_mult2x32 u_mul (
        .clk          (clk),
        .rst          (rst),
        .input_a      (w_mul_a),
        .input_a_stb  (w_mul_a_stb),
        .input_a_ack  (w_mul_a_ack),
        .input_b      (w_mul_b),
        .input_b_stb  (w_mul_b_stb),
        .input_b_ack  (w_mul_b_ack),
        .output_z     (w_mul_z),
        .output_z_stb (w_mul_z_stb),
        .output_z_ack (w_mul_z_ack)
    );

    fp_adder_2x32 u_add (
        .clk          (clk),
        .rst          (rst),
        .input_a      (w_add_a),
        .input_a_stb  (w_add_a_stb),
        .input_a_ack  (w_add_a_ack),
        .input_b      (w_add_b),
        .input_b_stb  (w_add_b_stb),
        .input_b_ack  (w_add_b_ack),
        .output_z     (w_add_z),
        .output_z_stb (w_add_z_stb),
        .output_z_ack (w_add_z_ack)
    );

endmodule
`default_nettype wire
